// File: rtl/obs_pkg.sv
// Shared constants and types for the OBS-L4 93-bit GF(2) multiplier front end.
package obs_pkg;

  localparam int N = 94;
  localparam int H = N / 2;

  // Tag order matches overlap stage inputs 1..4.
  localparam logic [1:0] TAG_EE = 2'd0;
  localparam logic [1:0] TAG_EO = 2'd1;
  localparam logic [1:0] TAG_OE = 2'd2;
  localparam logic [1:0] TAG_OO = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/obs_even_odd_split.sv
// Splits an (N-1)-bit polynomial into even-index and odd-index coefficient halves.
module obs_even_odd_split #(
  parameter int N = 94
) (
  input  logic [N-2:0]   vec_i,
  output logic [N/2-1:0] even_o,
  output logic [N/2-1:0] odd_o
);

  // Coefficient positions beyond the operand width read as zero (ao[46] here).
  for (genvar i = 0; i < N / 2; i++) begin : g_bit
    if (2 * i < N - 1) begin : g_even
      assign even_o[i] = vec_i[2*i];
    end else begin : g_even_pad
      assign even_o[i] = 1'b0;
    end
    if (2 * i + 1 < N - 1) begin : g_odd
      assign odd_o[i] = vec_i[2*i+1];
    end else begin : g_odd_pad
      assign odd_o[i] = 1'b0;
    end
  end

endmodule

// File: rtl/obs_split_issue_93bit.sv
// Captures a 93-bit operand pair, splits it even/odd and issues the four
// half-size sub-products (ee, eo, oe, oo) to the shared sub-multiplier.
module obs_split_issue_93bit
  import obs_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-2:0] A_in,
  input  logic [N-2:0] B_in,
  output logic         sub_valid,
  input  logic         sub_ready,
  output logic [H-1:0] sub_a,
  output logic [H-1:0] sub_b,
  output logic [1:0]   sub_tag,
  output logic         sub_last,
  output logic         busy
);

  state_e       state_q;
  logic [1:0]   cnt_q;
  logic [H-1:0] ae_q, ao_q, be_q, bo_q;
  logic [H-1:0] ae_d, ao_d, be_d, bo_d;
  logic         accept;
  logic         last_beat;

  obs_even_odd_split #(.N(N)) u_split_a (
    .vec_i  (A_in),
    .even_o (ae_d),
    .odd_o  (ao_d)
  );

  obs_even_odd_split #(.N(N)) u_split_b (
    .vec_i  (B_in),
    .even_o (be_d),
    .odd_o  (bo_d)
  );

  // in_ready depends combinationally on sub_ready so the next pair can be
  // taken on the tag-3 handshake edge without a bubble.
  assign last_beat = (state_q == ISSUE) && (cnt_q == TAG_OO);
  assign in_ready  = rst_n && ((state_q == IDLE) || (last_beat && sub_ready));
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= TAG_EE;
      ae_q    <= '0;
      ao_q    <= '0;
      be_q    <= '0;
      bo_q    <= '0;
    end else if (accept) begin
      state_q <= ISSUE;
      cnt_q   <= TAG_EE;
      ae_q    <= ae_d;
      ao_q    <= ao_d;
      be_q    <= be_d;
      bo_q    <= bo_d;
    end else if (state_q == ISSUE && sub_ready) begin
      if (cnt_q == TAG_OO) begin
        state_q <= IDLE;
        cnt_q   <= TAG_EE;
      end else begin
        cnt_q   <= cnt_q + 2'd1;
      end
    end
  end

  // Tag bit 1 selects A's half, tag bit 0 selects B's half.
  assign sub_valid = (state_q == ISSUE);
  assign busy      = (state_q == ISSUE);
  assign sub_tag   = cnt_q;
  assign sub_a     = cnt_q[1] ? ao_q : ae_q;
  assign sub_b     = cnt_q[0] ? bo_q : be_q;
  assign sub_last  = last_beat;

endmodule

// File: doc/obs_split_issue_93bit.md
Name: obs_split_issue_93bit

Overview:
- Front end of the OBS-L4 93-bit GF(2) multiplier; the counterpart of the overlap recombiner.
- Accepts one pair of 93-bit operands per handshake and splits each into even-index and odd-index coefficient halves.
- Sequentially issues the four half-size sub-products (ee, eo, oe, oo) to the shared sub-multiplier over a valid/ready handshake.
- Sub-multiplier results are tagged so each lands on overlap stage input 1..4 (tag 0..3).

Parameters:
- N, 94: operand width is N-1 (93 bits); matches the overlap stage.
- H, N/2 (47): sub-operand width.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- in_valid, input, 1: operand pair valid.
- in_ready, output, 1: block can accept an operand pair.
- A_in, input, N-1: operand A, bit i = coefficient of x^i.
- B_in, input, N-1: operand B.
- sub_valid, output, 1: sub-product request valid.
- sub_ready, input, 1: sub-multiplier accepts the request.
- sub_a, output, H: left sub-operand.
- sub_b, output, H: right sub-operand.
- sub_tag, output, 2: 0 = ae·be, 1 = ae·bo, 2 = ao·be, 3 = ao·bo (overlap inputs 1, 2, 3, 4).
- sub_last, output, 1: high with tag 3.
- busy, output, 1: operand pair held, issue in progress.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Split rule:
  - ae[i] = A[2i] for i = 0..46.
  - ao[i] = A[2i+1] for i = 0..45; ao[46] = 0.
  - B splits the same way into be and bo.
- Split halves are registered at input acceptance (in_valid & in_ready). A_in/B_in are not sampled afterwards.
- FSM states:
  - IDLE: sub_valid = 0, busy = 0.
  - ISSUE: 2-bit counter cnt drives sub_tag. sub_a/sub_b are selected from the registered halves per tag. sub_valid = 1, busy = 1.
- Transitions:
  - IDLE -> ISSUE on accept, with cnt = 0.
  - In ISSUE, on sub_valid & sub_ready: if cnt < 3, cnt increments. If cnt = 3: with in_valid, accept new operands and stay in ISSUE with cnt = 0 (back-to-back). Otherwise go to IDLE.
- in_ready = rst_n & (IDLE | (ISSUE & cnt == 3 & sub_ready)). This is combinational from sub_ready and documented as such. No combinational path from in_valid to any output.
- Latency: accept at edge k -> tag 0 visible after edge k. With sub_ready held high, tags 0..3 appear on four consecutive cycles. Sustained throughput is one operand pair per 4 cycles.
- Backpressure: while sub_valid & !sub_ready, sub_a, sub_b, sub_tag, sub_last and sub_valid hold stable. No tag is skipped or repeated.
- sub_valid never drops without a handshake.
- sub_last = (cnt == 3) & sub_valid.
- Reset, including mid-ISSUE:
  - Next edge returns to IDLE; the in-flight operand pair is discarded.
  - sub_valid = 0, sub_a = 0, sub_b = 0, sub_tag = 0, sub_last = 0, busy = 0, cnt = 0, operand registers = 0.
  - in_ready = 0 while rst_n is low.
- Simultaneous tag-3 handshake and in_valid: the new pair is accepted the same edge; no bubble cycle.
- in_valid while busy (cnt != 3 or !sub_ready): not accepted; the producer must hold.

Decomposition:
- Package obs_pkg:
  - Constants N and H.
  - Tag constants TAG_EE = 0, TAG_EO = 1, TAG_OE = 2, TAG_OO = 3.
  - State enum {IDLE, ISSUE}.
- Sub-module obs_even_odd_split (combinational, parameter N): A -> {ae, ao}. Instantiated twice (A, B) and reusable by the overlap-side checker model.

Test Plan:
- A = 1, B = 1, sub_ready = 1 -> tags 0..3 on 4 consecutive cycles with (sub_a, sub_b) = (1,1), (1,0), (0,1), (0,0); sub_last only on tag 3; busy drops after.
- A = 2, B = 3 -> (0,1), (0,1), (1,1), (1,1).
- A = all-ones (93 bits), B = 0 -> tags 0, 1: sub_a = 47'h7FFF_FFFF_FFFF; tags 2, 3: sub_a = 47'h3FFF_FFFF_FFFF (ao[46] = 0); sub_b = 0 throughout.
- Hold sub_ready low for 3 cycles while tag 2 is presented -> outputs frozen, then tags 2 and 3 issue in order; in_ready = 0 throughout.
- Two pairs with in_valid continuously high and sub_ready = 1 -> 8 consecutive sub_valid cycles with tags 0,1,2,3,0,1,2,3; second pair accepted on the first pair's tag-3 edge.
- Assert rst_n = 0 for one cycle during tag 1 -> next cycle all outputs zero, in_ready = 0 during reset and 1 after; a fresh pair then restarts at tag 0.
